// File: rtl/alu_flag_ir_unit.sv
// rtl/alu_flag_ir_unit.sv - 32-bit ALU with flag register (FDR) and instruction register (IR)
// Optional extended opcodes 16-19 enabled by macro ALU_EXT_OPS_EN.
module alu_flag_ir_unit (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  OP,
    input  logic        FRLd,
    input  logic        IRLd,
    input  logic [31:0] MemData,
    output logic [31:0] result,
    output logic        FlagN,
    output logic        FlagZ,
    output logic        FlagC,
    output logic        FlagV,
    output logic [3:0]  FDROut,
    output logic [31:0] IROut
);

    logic [3:0]  fdr_q, fdr_d;
    logic [31:0] ir_q, ir_d;

    logic        cin, vs;
    logic        arith;
    logic [31:0] add_x, add_y;
    logic        add_c;
    logic [32:0] sum;

    assign cin = fdr_q[1];
    assign vs  = fdr_q[0];

    // Every arithmetic opcode is mapped onto one shared adder: x + y + c.
    always_comb begin
        add_x = A;
        add_y = B;
        add_c = 1'b0;
        arith = 1'b0;
        case (OP)
            5'd2, 5'd10: begin add_y = ~B; add_c = 1'b1; arith = 1'b1; end
            5'd3:        begin add_x = B; add_y = ~A; add_c = 1'b1; arith = 1'b1; end
            5'd4, 5'd11: begin arith = 1'b1; end
            5'd5:        begin add_c = cin; arith = 1'b1; end
            5'd6:        begin add_y = ~B; add_c = cin; arith = 1'b1; end
            5'd7:        begin add_x = B; add_y = ~A; add_c = cin; arith = 1'b1; end
            default:     begin end
        endcase
        sum = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_c};
    end

    always_comb begin
        result = 32'h0;
        case (OP)
            5'd0, 5'd8:  result = A & B;
            5'd1, 5'd9:  result = A ^ B;
            5'd2, 5'd3, 5'd4, 5'd5,
            5'd6, 5'd7, 5'd10, 5'd11: result = sum[31:0];
            5'd12:       result = A | B;
            5'd13:       result = B;
            5'd14:       result = A & ~B;
            5'd15:       result = ~B;
`ifdef ALU_EXT_OPS_EN
            5'd16:       result = A;
            5'd17:       result = B;
            5'd18:       result = A + 32'd4;
            5'd19:       result = A + B + 32'd4;
`endif
            default:     result = 32'h0;
        endcase
    end

    // Non-arithmetic ops pass the stored C and V straight through.
    always_comb begin
        FlagN = result[31];
        FlagZ = (result == 32'h0);
        FlagC = arith ? sum[32] : cin;
        FlagV = arith ? ((add_x[31] == add_y[31]) && (sum[31] != add_x[31])) : vs;
    end

    always_comb begin
        fdr_d = fdr_q;
        ir_d  = ir_q;
        if (FRLd) fdr_d = {FlagN, FlagZ, FlagC, FlagV};
        if (IRLd) ir_d  = MemData;
    end

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            fdr_q <= 4'b0000;
            ir_q  <= 32'h0;
        end else begin
            fdr_q <= fdr_d;
            ir_q  <= ir_d;
        end
    end

    assign FDROut = fdr_q;
    assign IROut  = ir_q;

endmodule

// File: tb/tb_alu_flag_ir_unit.sv
// tb/tb_alu_flag_ir_unit.sv - directed self-checking bench for alu_flag_ir_unit
module tb_alu_flag_ir_unit;

    logic        CLK = 1'b0;
    logic        CLR;
    logic [31:0] A, B, MemData;
    logic [4:0]  OP;
    logic        FRLd, IRLd;
    logic [31:0] result, IROut;
    logic        FlagN, FlagZ, FlagC, FlagV;
    logic [3:0]  FDROut;

    int total = 0;
    int bad   = 0;

    alu_flag_ir_unit dut (
        .CLK(CLK), .CLR(CLR), .A(A), .B(B), .OP(OP),
        .FRLd(FRLd), .IRLd(IRLd), .MemData(MemData),
        .result(result), .FlagN(FlagN), .FlagZ(FlagZ), .FlagC(FlagC), .FlagV(FlagV),
        .FDROut(FDROut), .IROut(IROut)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        OP = op; A = a; B = b;
        #1;
    endtask

    task automatic test_reset();
        CLR = 1'b0; FRLd = 1'b0; IRLd = 1'b0; MemData = 32'h0;
        alu(5'd0, 32'h0, 32'h0);
        tick();
        CLR = 1'b1;
        total++;
        if (FDROut !== 4'b0000) begin bad++; $display("FAIL reset_fdr got=%b exp=%b", FDROut, 4'b0000); end
        total++;
        if (IROut !== 32'h0) begin bad++; $display("FAIL reset_ir got=%h exp=%h", IROut, 32'h0); end
    endtask

    task automatic test_add_carry();
        FRLd = 1'b1;
        alu(5'd4, 32'hFFFFFFFF, 32'h1);
        total++;
        if ({result, FlagN, FlagZ, FlagC, FlagV} !== {32'h0, 4'b0110})
            begin bad++; $display("FAIL add_wrap got=%h/%b exp=00000000/0110", result, {FlagN, FlagZ, FlagC, FlagV}); end
        tick();
        FRLd = 1'b0;
        total++;
        if (FDROut !== 4'b0110) begin bad++; $display("FAIL add_fdr_load got=%b exp=0110", FDROut); end
    endtask

    task automatic test_sub_cmp();
        alu(5'd2, 32'd5, 32'd7);
        total++;
        if ({result, FlagN, FlagZ, FlagC, FlagV} !== {32'hFFFFFFFE, 4'b1000})
            begin bad++; $display("FAIL sub_borrow got=%h/%b exp=fffffffe/1000", result, {FlagN, FlagZ, FlagC, FlagV}); end
        alu(5'd10, 32'd7, 32'd7);
        total++;
        if ({result, FlagN, FlagZ, FlagC, FlagV} !== {32'h0, 4'b0110})
            begin bad++; $display("FAIL cmp_equal got=%h/%b exp=00000000/0110", result, {FlagN, FlagZ, FlagC, FlagV}); end
        alu(5'd3, 32'd1, 32'd0);
        total++;
        if ({result, FlagN, FlagZ, FlagC, FlagV} !== {32'hFFFFFFFF, 4'b1000})
            begin bad++; $display("FAIL rsb got=%h/%b exp=ffffffff/1000", result, {FlagN, FlagZ, FlagC, FlagV}); end
    endtask

    task automatic test_overflow_adc();
        alu(5'd4, 32'h7FFFFFFF, 32'h1);
        total++;
        if ({result, FlagN, FlagZ, FlagC, FlagV} !== {32'h80000000, 4'b1001})
            begin bad++; $display("FAIL add_ovf got=%h/%b exp=80000000/1001", result, {FlagN, FlagZ, FlagC, FlagV}); end
        // Load C=1 via CMP 7,7, then ADC consumes it
        FRLd = 1'b1;
        alu(5'd10, 32'd7, 32'd7);
        tick();
        FRLd = 1'b0;
        alu(5'd5, 32'd2, 32'd3);
        total++;
        if ({result, FlagN, FlagZ, FlagC, FlagV} !== {32'd6, 4'b0000})
            begin bad++; $display("FAIL adc_cin1 got=%h/%b exp=00000006/0000", result, {FlagN, FlagZ, FlagC, FlagV}); end
    endtask

    task automatic test_logical_passthrough();
        // FDR holds 0110: C=1, V=0
        alu(5'd0, 32'hF0, 32'h3C);
        total++;
        if ({result, FlagN, FlagZ, FlagC, FlagV} !== {32'h30, 4'b0010})
            begin bad++; $display("FAIL and_pass got=%h/%b exp=00000030/0010", result, {FlagN, FlagZ, FlagC, FlagV}); end
        alu(5'd14, 32'hFF, 32'h0F);
        total++;
        if (result !== 32'hF0) begin bad++; $display("FAIL bic got=%h exp=000000f0", result); end
        // Store 1001 (C=0, V=1) from an overflowing ADD
        FRLd = 1'b1;
        alu(5'd4, 32'h7FFFFFFF, 32'h1);
        tick();
        FRLd = 1'b0;
        alu(5'd15, 32'h0, 32'h0);
        total++;
        if ({result, FlagN, FlagZ, FlagC, FlagV} !== {32'hFFFFFFFF, 4'b1001})
            begin bad++; $display("FAIL mvn_pass got=%h/%b exp=ffffffff/1001", result, {FlagN, FlagZ, FlagC, FlagV}); end
        alu(5'd6, 32'h10, 32'h3);
        total++;
        if ({result, FlagN, FlagZ, FlagC, FlagV} !== {32'hC, 4'b0010})
            begin bad++; $display("FAIL sbc_cin0 got=%h/%b exp=0000000c/0010", result, {FlagN, FlagZ, FlagC, FlagV}); end
        alu(5'd7, 32'h3, 32'h10);
        total++;
        if ({result, FlagN, FlagZ, FlagC, FlagV} !== {32'hC, 4'b0010})
            begin bad++; $display("FAIL rsc_cin0 got=%h/%b exp=0000000c/0010", result, {FlagN, FlagZ, FlagC, FlagV}); end
    endtask

    task automatic test_ir();
        IRLd = 1'b1; MemData = 32'hE3A01005;
        tick();
        total++;
        if (IROut !== 32'hE3A01005) begin bad++; $display("FAIL ir_load got=%h exp=e3a01005", IROut); end
        IRLd = 1'b0; MemData = 32'h12345678;
        tick();
        total++;
        if (IROut !== 32'hE3A01005) begin bad++; $display("FAIL ir_hold got=%h exp=e3a01005", IROut); end
        // Both strobes on one edge: FDR takes CMP 7,7 flags
        IRLd = 1'b1; FRLd = 1'b1; MemData = 32'hA5A5_0F0F;
        alu(5'd10, 32'd7, 32'd7);
        tick();
        IRLd = 1'b0; FRLd = 1'b0;
        total++;
        if ({IROut, FDROut} !== {32'hA5A50F0F, 4'b0110})
            begin bad++; $display("FAIL dual_load got=%h/%b exp=a5a50f0f/0110", IROut, FDROut); end
    endtask

    task automatic test_reset_priority();
        CLR = 1'b0; IRLd = 1'b1; FRLd = 1'b1; MemData = 32'hDEADBEEF;
        alu(5'd4, 32'hFFFFFFFF, 32'h1);
        tick();
        CLR = 1'b1; IRLd = 1'b0; FRLd = 1'b0;
        total++;
        if ({IROut, FDROut} !== {32'h0, 4'b0000})
            begin bad++; $display("FAIL reset_over_load got=%h/%b exp=00000000/0000", IROut, FDROut); end
        alu(5'd5, 32'd2, 32'd3);
        total++;
        if (result !== 32'd5) begin bad++; $display("FAIL adc_after_reset got=%h exp=00000005", result); end
    endtask

    task automatic test_ext_ops();
        // FDR is 0000 here
`ifdef ALU_EXT_OPS_EN
        alu(5'd18, 32'h100, 32'h0);
        total++;
        if (result !== 32'h104) begin bad++; $display("FAIL ext_a4 got=%h exp=00000104", result); end
        alu(5'd19, 32'h8, 32'h10);
        total++;
        if (result !== 32'h1C) begin bad++; $display("FAIL ext_ab4 got=%h exp=0000001c", result); end
        alu(5'd16, 32'h80000000, 32'h1);
        total++;
        if ({result, FlagN, FlagZ, FlagC, FlagV} !== {32'h80000000, 4'b1000})
            begin bad++; $display("FAIL ext_pass_a got=%h/%b exp=80000000/1000", result, {FlagN, FlagZ, FlagC, FlagV}); end
        alu(5'd25, 32'h5, 32'h6);
        total++;
        if ({result, FlagN, FlagZ, FlagC, FlagV} !== {32'h0, 4'b0100})
            begin bad++; $display("FAIL ext_zero got=%h/%b exp=00000000/0100", result, {FlagN, FlagZ, FlagC, FlagV}); end
`else
        alu(5'd18, 32'h100, 32'h0);
        total++;
        if ({result, FlagN, FlagZ, FlagC, FlagV} !== {32'h0, 4'b0100})
            begin bad++; $display("FAIL ext_off got=%h/%b exp=00000000/0100", result, {FlagN, FlagZ, FlagC, FlagV}); end
        alu(5'd17, 32'h0, 32'hFFFFFFFF);
        total++;
        if (result !== 32'h0) begin bad++; $display("FAIL ext_off_b got=%h exp=00000000", result); end
`endif
        // Extended ops pass stored C/V: load 0110 then check C under OP[4]=1
        FRLd = 1'b1;
        alu(5'd10, 32'd7, 32'd7);
        tick();
        FRLd = 1'b0;
        alu(5'd31, 32'h1, 32'h1);
        total++;
        if ({result, FlagN, FlagZ, FlagC, FlagV} !== {32'h0, 4'b0110})
            begin bad++; $display("FAIL ext_flag_pass got=%h/%b exp=00000000/0110", result, {FlagN, FlagZ, FlagC, FlagV}); end
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_sub_cmp();
        test_overflow_adc();
        test_logical_passthrough();
        test_ir();
        test_reset_priority();
        test_ext_ops();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_flag_ir_unit.md
# alu_flag_ir_unit

Execution datapath slice of the multicycle ARM-style CPU. It contains the 32-bit combinational ALU, the 4-bit flag register (FDR) and the 32-bit instruction register (IR). ALU inputs come from the register-file / shifter muxes. The control unit drives the 5-bit opcode and the FDR and IR load strobes. The IR feeds the control unit, the operand muxes and the condition tester.

## Interface
- No parameters; all widths are fixed at 32-bit data, 5-bit opcode and 4-bit flags.
- CLK  in  1  single system clock; all state updates on its rising edge.
- CLR  in  1  reset; synchronous, active-low; clears FDR and IR.
- A  in  32  ALU operand A (port-A path).
- B  in  32  ALU operand B (mux-B path).
- OP  in  5  ALU operation select.
- FRLd  in  1  loads ALU flags into FDR.
- IRLd  in  1  loads MemData into IR.
- MemData  in  32  memory read data (RAM DaOut).
- result  out  32  ALU result; combinational.
- FlagN, FlagZ, FlagC, FlagV  out  1 each  ALU flags; combinational.
- FDROut  out  4  stored flags {N,Z,C,V}.
- IROut  out  32  stored instruction.

## Operation
- The ALU carry-in is FDROut[1], the stored C flag. "Cin" below means FDROut[1] and "Vs" means FDROut[0].
- Opcodes 0-15 follow ARM data-processing encoding. All arithmetic is modulo 2^32.
  - 0 AND: A&B
  - 1 EOR: A^B
  - 2 SUB: A+~B+1
  - 3 RSB: B+~A+1
  - 4 ADD: A+B
  - 5 ADC: A+B+Cin
  - 6 SBC: A+~B+Cin
  - 7 RSC: B+~A+Cin
  - 8 TST: A&B
  - 9 TEQ: A^B
  - 10 CMP: A+~B+1
  - 11 CMN: A+B
  - 12 ORR: A|B
  - 13 MOV: B
  - 14 BIC: A&~B
  - 15 MVN: ~B
- TST/TEQ/CMP/CMN still drive the computed value on `result`. Suppressing the register write is the control unit's job.
- N = result[31]; Z = (result==0).
- Arithmetic ops:
  - C = carry-out of bit 31 of the 33-bit sum. For subtracts this is NOT-borrow, so 5-7 gives C=0.
  - V = signed overflow of the performed addition, i.e. the two addends have the same sign and the result sign differs.
- Logical ops and MOV/MVN: C = Cin, V = Vs (stored flags are passed through unchanged).
- Extended opcodes (see Configuration), for control-unit address arithmetic:
  - 16 pass A
  - 17 pass B
  - 18 A+4
  - 19 A+B+4
  - 20-31 result 0
  - N and Z are computed as usual; C = Cin, V = Vs.
- FDR: on a rising edge with CLR=1 and FRLd=1, FDROut <= {FlagN,FlagZ,FlagC,FlagV}; otherwise it holds.
- IR: on a rising edge with CLR=1 and IRLd=1, IROut <= MemData; otherwise it holds.

## Timing
- The ALU is purely combinational with zero-cycle latency. Flags are valid in the same cycle as A, B and OP.
- FDR and IR each have one-cycle load latency: the new value is visible after the loading edge.
- Reset: CLR=0 at a rising edge forces FDROut=4'b0000 and IROut=32'h0. Reset beats load, so FRLd and IRLd are ignored while CLR=0.
- Before the first reset edge, FDROut and IROut are undefined.
- FRLd and IRLd are independent; both may load on the same edge.
- ADC/SBC/RSC use the FDR value present before the edge. Loading FDR from an ADC therefore never forms a combinational loop.
- A reset mid-sequence discards the stored carry; subsequent ADC behaves as Cin=0.

## Configuration
- Macro: ALU_EXT_OPS_EN.
- Defined: opcodes 16-19 behave as listed; 20-31 give result 0.
- Undefined: every opcode with OP[4]=1 gives result=32'h0, N=0, Z=1, C=Cin, V=Vs. Opcodes 0-15 are unaffected.

## Test plan
- ADD, A=FFFFFFFF, B=1, FRLd=1 -> result 0, NZCV=0110, and FDROut=4'b0110 after the edge.
- SUB, A=5, B=7 -> result FFFFFFFE, NZCV=1000. CMP, A=7, B=7 -> Z=1, C=1.
- ADD, A=7FFFFFFF, B=1 -> result 80000000, N=1, V=1, C=0. Then ADC with stored C=1, A=2, B=3 -> result 6.
- IRLd=1, MemData=E3A01005 -> IROut=E3A01005 next cycle. Hold IRLd=0 with other MemData -> unchanged.
- CLR=0 with IRLd=1 and FRLd=1 at the same edge -> IROut=0, FDROut=0.
- With ALU_EXT_OPS_EN defined: OP=18, A=100 -> result 104; OP=19, A=8, B=10 -> result 1C. Without the macro: OP=18 -> result 0, Z=1.
